// File: rtl/pwm_bank.sv
// Bank of NUM_CH PWM channels sharing one prescaler and one period counter.
// DUTY and TOP are double-buffered and move to their active copies only at the period wrap.
module pwm_bank #(
    parameter int NUM_CH = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [7:0]        wr_addr,
    input  logic [7:0]        wr_data,
    output logic [NUM_CH-1:0] out,
    output logic              period_start,
    output logic              wr_err
);

    localparam int          NB   = NUM_CH / 8;
    localparam logic [7:0]  NB8  = 8'(NB);
    localparam logic [7:0]  NCH8 = 8'(NUM_CH);

    logic [NUM_CH-1:0] out_en_q, out_en_d;
    logic [NUM_CH-1:0] pwm_en_q, pwm_en_d;
    logic [7:0]        presc_q, presc_d;
    logic [7:0]        top_sh_q, top_sh_d;
    logic [7:0]        top_act_q, top_act_d;
    logic [7:0]        pc_q, pc_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [7:0]        duty_sh_q  [NUM_CH];
    logic [7:0]        duty_sh_d  [NUM_CH];
    logic [7:0]        duty_act_q [NUM_CH];
    logic [7:0]        duty_act_d [NUM_CH];
    logic [NUM_CH-1:0] out_q, out_d;
    logic              period_start_q, period_start_d;
    logic              wr_err_q, wr_err_d;

    logic sel_oe, sel_pe, sel_presc, sel_top, sel_duty;
    logic tick, wrap;

    // Address decode; anything outside these windows is flagged as an error.
    always_comb begin
        sel_oe    = wr_en && (wr_addr < NB8);
        sel_pe    = wr_en && (wr_addr >= 8'h10) && (wr_addr < (8'h10 + NB8));
        sel_presc = wr_en && (wr_addr == 8'h20);
        sel_top   = wr_en && (wr_addr == 8'h21);
        sel_duty  = wr_en && (wr_addr >= 8'h40) && (wr_addr < (8'h40 + NCH8));
        wr_err_d  = wr_en && !(sel_oe || sel_pe || sel_presc || sel_top || sel_duty);
    end

    always_comb begin
        out_en_d = out_en_q;
        pwm_en_d = pwm_en_q;
        presc_d  = sel_presc ? wr_data : presc_q;
        top_sh_d = sel_top ? wr_data : top_sh_q;
        for (int k = 0; k < NB; k++) begin
            if (sel_oe && (wr_addr[1:0] == 2'(k))) out_en_d[k*8 +: 8] = wr_data;
            if (sel_pe && (wr_addr[1:0] == 2'(k))) pwm_en_d[k*8 +: 8] = wr_data;
        end
        for (int i = 0; i < NUM_CH; i++) begin
            duty_sh_d[i] = duty_sh_q[i];
            if (sel_duty && (wr_addr[4:0] == 5'(i))) duty_sh_d[i] = wr_data;
        end
    end

    // Compare with >= so a PRESC lowered below pc ticks at once instead of rolling over.
    always_comb begin
        tick           = (pc_q >= presc_q);
        wrap           = tick && (cnt_q >= top_act_q);
        pc_d           = tick ? 8'd0 : pc_q + 8'd1;
        cnt_d          = cnt_q;
        if (tick) cnt_d = wrap ? 8'd0 : cnt_q + 8'd1;
        top_act_d      = wrap ? top_sh_q : top_act_q;
        period_start_d = wrap;
        for (int i = 0; i < NUM_CH; i++) begin
            duty_act_d[i] = wrap ? duty_sh_q[i] : duty_act_q[i];
        end
    end

    always_comb begin
        out_d = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (!out_en_q[i])      out_d[i] = 1'b0;
            else if (!pwm_en_q[i]) out_d[i] = 1'b1;
            else                   out_d[i] = (duty_act_q[i] == 8'hFF) || (cnt_q < duty_act_q[i]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_en_q       <= '0;
            pwm_en_q       <= '0;
            presc_q        <= 8'd0;
            top_sh_q       <= 8'hFF;
            top_act_q      <= 8'hFF;
            pc_q           <= 8'd0;
            cnt_q          <= 8'd0;
            out_q          <= '0;
            period_start_q <= 1'b0;
            wr_err_q       <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                duty_sh_q[i]  <= 8'd0;
                duty_act_q[i] <= 8'd0;
            end
        end else begin
            out_en_q       <= out_en_d;
            pwm_en_q       <= pwm_en_d;
            presc_q        <= presc_d;
            top_sh_q       <= top_sh_d;
            top_act_q      <= top_act_d;
            pc_q           <= pc_d;
            cnt_q          <= cnt_d;
            out_q          <= out_d;
            period_start_q <= period_start_d;
            wr_err_q       <= wr_err_d;
            for (int i = 0; i < NUM_CH; i++) begin
                duty_sh_q[i]  <= duty_sh_d[i];
                duty_act_q[i] <= duty_act_d[i];
            end
        end
    end

    assign out          = out_q;
    assign period_start = period_start_q;
    assign wr_err       = wr_err_q;

endmodule

// File: doc/pwm_bank.md
PWM_BANK -- requirements
Module: pwm_bank

Interface
REQ-001 The module SHALL have parameter NUM_CH, default 16, meaning the number of PWM channels; legal values are 8, 16, 24 or 32.
REQ-002 The module SHALL have port clk, input, 1 bit, meaning the single system clock; all state changes on its rising edge.
REQ-003 The module SHALL have port rst_n, input, 1 bit; reset is asynchronous and active-low.
REQ-004 The module SHALL have port wr_en, input, 1 bit, meaning a register write strobe, sampled each clk edge.
REQ-005 The module SHALL have port wr_addr, input, 8 bits, meaning the register address.
REQ-006 The module SHALL have port wr_data, input, 8 bits, meaning the register write data.
REQ-007 The module SHALL have port out, output, NUM_CH bits, meaning the registered channel outputs.
REQ-008 The module SHALL have port period_start, output, 1 bit, meaning a 1-cycle pulse at each PWM period boundary.
REQ-009 The module SHALL have port wr_err, output, 1 bit, meaning a 1-cycle pulse after a write to an unmapped address.

Function
REQ-010 Register map: 0x00+k is OUT_EN byte k and 0x10+k is PWM_EN byte k, for k < NUM_CH/8; 0x20 is PRESC; 0x21 is TOP; 0x40+i is DUTY shadow for channel i, for i < NUM_CH.
REQ-011 A write with wr_en=1 SHALL update the addressed register at that clk edge; a write to any other address SHALL change no state and SHALL assert wr_err for the next cycle only.
REQ-012 OUT_EN, PWM_EN and PRESC SHALL take effect immediately; DUTY and TOP writes SHALL go to shadow registers only.
REQ-013 Prescaler counter pc (8 bits): when pc >= PRESC, tick=1 and pc<=0; otherwise pc<=pc+1.
REQ-014 Period counter cnt (8 bits) SHALL advance only on tick: when cnt >= TOP_act, cnt<=0 (wrap); otherwise cnt<=cnt+1.
REQ-015 Period length SHALL be (TOP_act+1)*(PRESC+1) clocks with constant PRESC.
REQ-016 On the wrap edge, every DUTY_act[i] SHALL load from DUTY_sh[i] and TOP_act SHALL load from TOP_sh, using shadow values held before that edge; a shadow write on the wrap edge takes effect at the following wrap.
REQ-017 period_start SHALL be 1 in exactly the cycle after each wrap edge, and 0 otherwise.
REQ-018 Channel i next value: OUT_EN[i]=0 gives 0; OUT_EN[i]=1 and PWM_EN[i]=0 gives 1; both enabled gives (DUTY_act[i]==0xFF) | (cnt < DUTY_act[i]).
REQ-019 out SHALL be registered, with one clk latency from cnt, enable or DUTY_act changes.
REQ-020 DUTY_act[i]=0 with PWM enabled SHALL hold the output at constant 0; DUTY_act[i] > TOP_act SHALL hold it at constant 1.
REQ-021 Lowering PRESC below the current pc SHALL produce a tick on the next edge, with no 256-cycle wrap.
REQ-022 Compare logic SHALL be unsigned 8-bit with no overflow; cnt never exceeds TOP_act.

Reset
REQ-023 While rst_n=0, the following SHALL hold: OUT_EN, PWM_EN, PRESC, pc, cnt and all DUTY shadow and active registers = 0; TOP_sh = TOP_act = 0xFF; out = 0; period_start = 0; wr_err = 0.
REQ-024 Reset asserted mid-period SHALL clear all state asynchronously, with no wait for clk.
REQ-025 After release, counting SHALL start at the first clk edge with rst_n=1.

Verification
REQ-026 The bench SHALL cover these directed scenarios:
- Reset then write OUT_EN0=0xFF and PWM_EN0=0x00 -> out[7:0]=0xFF one cycle after the write; other bits 0.
- TOP=0xFF, PRESC=0, ch0 DUTY=0x80, both enables set -> after the next wrap, out[0] is high for 128 and low for 128 clocks; period_start pulses every 256 clocks.
- PRESC=3, TOP=9, ch1 DUTY=5 -> period of 40 clocks; out[1] high for 20 clocks per period.
- Change ch0 DUTY from 0x40 to 0xC0 mid-period -> the current period still shows 64 high clocks; the change applies only after the next period_start.
- DUTY 0x00 and 0xFF on two channels -> outputs are constant 0 and constant 1; a write to 0x30 -> wr_err is a single pulse with no register change.
- Assert rst_n low mid-period with outputs high -> out=0 immediately; registers return to reset values.
